// File: rtl/vga_sync_generator.sv
// VGA raster timing generator: horizontal/vertical counters with registered, zero-skew
// sync, active-video and line/frame start outputs, gated by a pixel-rate enable.
module vga_sync_generator #(
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FP      = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BP      = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FP      = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BP      = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   CNT_W     = 12
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             pixelEn,
   input  logic             enable,
   output logic [CNT_W-1:0] hCount,
   output logic [CNT_W-1:0] vCount,
   output logic             hSync,
   output logic             vSync,
   output logic             videoActive,
   output logic             lineStart,
   output logic             frameStart
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;
   logic             h_wrap;
   logic             hs_next;
   logic             vs_next;
   logic             va_next;
   logic             ls_next;
   logic             fs_next;

   // The idle position is the frame's last pixel, so dropping enable simply forces the
   // next position there; restarting then falls out of the ordinary wrap to (0,0).
   always_comb begin
      // NOTE: every signal gets a default at the top so no path can leave it unassigned
      // and infer a latch.
      h_wrap = (hCount == H_LAST);
      h_next = h_wrap ? '0 : hCount + CNT_W'(1);
      v_next = vCount;
      if (h_wrap) begin
         v_next = (vCount == V_LAST) ? '0 : vCount + CNT_W'(1);
      end
      if (!enable) begin
         h_next = H_LAST;
         v_next = V_LAST;
      end

      hs_next = ((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
      vs_next = ((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
      va_next = (h_next < H_ACT_END) && (v_next < V_ACT_END);
      ls_next = (h_next == '0);
      fs_next = (h_next == '0) && (v_next == '0);
   end

   // Decodes are taken from the next position so outputs line up with the counters.
   always_ff @(posedge clk or negedge resetN) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      if (!resetN) begin
         hCount      <= H_LAST;
         vCount      <= V_LAST;
         hSync       <= ~HSYNC_POL;
         vSync       <= ~VSYNC_POL;
         videoActive <= 1'b0;
         lineStart   <= 1'b0;
         frameStart  <= 1'b0;
      end else if (pixelEn) begin
         hCount      <= h_next;
         vCount      <= v_next;
         hSync       <= hs_next;
         vSync       <= vs_next;
         videoActive <= va_next;
         lineStart   <= ls_next;
         frameStart  <= fs_next;
      end
   end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench: the driver models the raster as a linear pixel index per frame and queues
// the expected outputs; a monitor pops and compares after every clock edge.
module tb_vga_sync_generator;

   typedef struct packed {
      logic [11:0] h;
      logic [11:0] v;
      logic        hs;
      logic        vs;
      logic        va;
      logic        ls;
      logic        fs;
   } out_t;

   typedef struct {
      int ha, hf, hs, hb;
      int va, vf, vs, vb;
      bit hp, vp;
   } cfg_t;

   logic clk = 1'b0;
   logic resetN = 1'b1;
   logic pixelEn = 1'b0;
   logic enable = 1'b0;

   logic [11:0] hc_d, vc_d, hc_s, vc_s;
   logic hs_d, vs_d, va_d, ls_d, fs_d;
   logic hs_s, vs_s, va_s, ls_s, fs_s;

   always #5 clk = ~clk;

   vga_sync_generator dut_d (
      .clk(clk), .resetN(resetN), .pixelEn(pixelEn), .enable(enable),
      .hCount(hc_d), .vCount(vc_d), .hSync(hs_d), .vSync(vs_d),
      .videoActive(va_d), .lineStart(ls_d), .frameStart(fs_d)
   );

   vga_sync_generator #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(12)
   ) dut_s (
      .clk(clk), .resetN(resetN), .pixelEn(pixelEn), .enable(enable),
      .hCount(hc_s), .vCount(vc_s), .hSync(hs_s), .vSync(vs_s),
      .videoActive(va_s), .lineStart(ls_s), .frameStart(fs_s)
   );

   cfg_t cfg_d, cfg_s;
   int   n_d, n_s;
   int   p_d, p_s;
   int   checks = 0;
   int   errors = 0;
   out_t q_d[$];
   out_t q_s[$];

   function automatic int frame_len(cfg_t c);
      return (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
   endfunction

   // Expected outputs for pixel index p within the frame, straight from the timing rules.
   function automatic out_t model_out(cfg_t c, int p);
      out_t r;
      int ht, x, y;
      ht   = c.ha + c.hf + c.hs + c.hb;
      x    = p % ht;
      y    = p / ht;
      r.h  = 12'(x);
      r.v  = 12'(y);
      r.hs = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
      r.vs = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.vp : !c.vp;
      r.va = (x < c.ha) && (y < c.va);
      r.ls = (x == 0);
      r.fs = (p == 0);
      return r;
   endfunction

   function automatic out_t cur_d();
      out_t o;
      o = {hc_d, vc_d, hs_d, vs_d, va_d, ls_d, fs_d};
      return o;
   endfunction

   function automatic out_t cur_s();
      out_t o;
      o = {hc_s, vc_s, hs_s, vs_s, va_s, ls_s, fs_s};
      return o;
   endfunction

   task automatic check(string name, out_t act, out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b va=%b ls=%b fs=%b expected h=%0d v=%0d hs=%b vs=%b va=%b ls=%b fs=%b",
                  name, $time, act.h, act.v, act.hs, act.vs, act.va, act.ls, act.fs,
                  exp.h, exp.v, exp.hs, exp.vs, exp.va, exp.ls, exp.fs);
      end
   endtask

   // One clock: drive inputs on the falling edge and queue what the next rising edge must produce.
   task automatic tick(bit rn, bit pe, bit en);
      @(negedge clk);
      resetN  = rn;
      pixelEn = pe;
      enable  = en;
      if (!rn) begin
         p_d = n_d - 1;
         p_s = n_s - 1;
      end else if (pe) begin
         p_d = en ? (p_d + 1) % n_d : n_d - 1;
         p_s = en ? (p_s + 1) % n_s : n_s - 1;
      end
      q_d.push_back(model_out(cfg_d, p_d));
      q_s.push_back(model_out(cfg_s, p_s));
   endtask

   // Reset asserted between clock edges must take effect without waiting for one.
   task automatic async_reset();
      @(negedge clk);
      pixelEn = 1'b1;
      enable  = 1'b1;
      #2 resetN = 1'b0;
      #1;
      p_d = n_d - 1;
      p_s = n_s - 1;
      check("async_rst_dflt", cur_d(), model_out(cfg_d, p_d));
      check("async_rst_small", cur_s(), model_out(cfg_s, p_s));
      q_d.push_back(model_out(cfg_d, p_d));
      q_s.push_back(model_out(cfg_s, p_s));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q_d.size() != 0) check("raster_dflt", cur_d(), q_d.pop_front());
         if (q_s.size() != 0) check("raster_small", cur_s(), q_s.pop_front());
      end
   end

   initial begin
      cfg_d = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, hp: 1'b0, vp: 1'b0};
      cfg_s = '{ha: 8, hf: 2, hs: 3, hb: 3, va: 4, vf: 1, vs: 1, vb: 1, hp: 1'b1, vp: 1'b1};
      n_d = frame_len(cfg_d);
      n_s = frame_len(cfg_s);
      p_d = n_d - 1;
      p_s = n_s - 1;

      // Reset before any clock edge, then held across a few edges.
      #1 resetN = 1'b0;
      #1;
      check("reset_idle_dflt", cur_d(), model_out(cfg_d, p_d));
      check("reset_idle_small", cur_s(), model_out(cfg_s, p_s));
      repeat (3) tick(1'b0, 1'b1, 1'b1);

      // Free run at full pixel rate: several default lines and many small frames.
      repeat (2000) tick(1'b1, 1'b1, 1'b1);

      // Pixel enable every fourth clock: state must hold between ticks.
      for (int i = 0; i < 1200; i++) tick(1'b1, (i % 4) == 3, 1'b1);

      // Drop enable while the small raster is inside vertical sync.
      for (int i = 0; i < 300; i++) begin
         tick(1'b1, 1'b1, 1'b1);
         if (p_s == 5 * 16 + 11) break;
      end
      tick(1'b1, 1'b1, 1'b0);
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      repeat (40) tick(1'b1, 1'b1, 1'b1);

      // Enable low without a pixel tick holds; idle only on the next tick.
      repeat (2) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      repeat (20) tick(1'b1, 1'b1, 1'b1);

      // Randomised pixel rate and occasional enable drops.
      repeat (3000) tick(1'b1, ($urandom % 3) != 0, ($urandom % 25) != 0);

      // Asynchronous reset mid-line at default hCount 300.
      for (int i = 0; i < 1000; i++) begin
         tick(1'b1, 1'b1, 1'b1);
         if (p_d % 800 == 300) break;
      end
      async_reset();
      repeat (3) tick(1'b0, 1'b1, 1'b1);
      repeat (900) tick(1'b1, 1'b1, 1'b1);

      repeat (3) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
